sar_adc_logic: RTL and testbench

- Control logic for an 8-bit differential charge-redistribution SAR ADC.
- Starts a conversion when cnvst goes high, then runs a sampling phase.
- Performs 8 MSB-first binary-search decisions using the comparator, and drives the switch controls for the two 9-bit fine capacitor arrays (true and complementary).
- Flags end of conversion with a one-cycle eoc pulse. Sits between the analog comparator/CDAC and the digital result consumer.

---
 rtl/sar_adc_logic_if.sv | 43 ++++
 rtl/sar_adc_logic.sv | 145 ++++++++++++++
 tb/tb_sar_adc_logic.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/sar_adc_logic_if.sv
`default_nettype none
// ============================================================================
// Module      : sar_adc_logic_if
// Description : Signal bundle between the SAR control logic (master) and the
//               analog front end / result consumer (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface sar_adc_logic_if;
  logic       cnvst;
  logic       cmp_out;
  logic [7:0] sar;
  logic       eoc;
  logic       cmp_clk;
  logic       s_clk;
  logic       s_clk_not;
  logic [8:0] fine_sca1_top;
  logic [8:0] fine_sca1_btm;
  logic [8:0] fine_sca2_top;
  logic [8:0] fine_sca2_btm;
  logic [8:0] fine_sca1_top_not;
  logic [8:0] fine_sca1_btm_not;
  logic [8:0] fine_sca2_top_not;
  logic [8:0] fine_sca2_btm_not;
  logic       fine_switch_S;
  logic       fine_switch_S_not;

  modport master (
    input  cnvst, cmp_out,
    output sar, eoc, cmp_clk, s_clk, s_clk_not,
    output fine_sca1_top, fine_sca1_btm, fine_sca2_top, fine_sca2_btm,
    output fine_sca1_top_not, fine_sca1_btm_not, fine_sca2_top_not, fine_sca2_btm_not,
    output fine_switch_S, fine_switch_S_not
  );

  modport slave (
    output cnvst, cmp_out,
    input  sar, eoc, cmp_clk, s_clk, s_clk_not,
    input  fine_sca1_top, fine_sca1_btm, fine_sca2_top, fine_sca2_btm,
    input  fine_sca1_top_not, fine_sca1_btm_not, fine_sca2_top_not, fine_sca2_btm_not,
    input  fine_switch_S, fine_switch_S_not
  );
endinterface
`default_nettype wire

// File: rtl/sar_adc_logic.sv
`default_nettype none
// ============================================================================
// Module      : sar_adc_logic
// Description : Control logic for an 8-bit differential charge-redistribution
//               SAR ADC: start detect, sampling phase, 8 MSB-first binary
//               search decisions, CDAC switch drive and end-of-conversion.
// Revision    : 1.0 - initial release
// ============================================================================
module sar_adc_logic #(
  parameter int SAMPLE_CYCLES = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  sar_adc_logic_if.master bus
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SAMPLE  = 3'd1;
  localparam logic [2:0] ST_BIT_CMP = 3'd2;
  localparam logic [2:0] ST_BIT_DEC = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  localparam int             CNT_W    = (SAMPLE_CYCLES > 2) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SMP_LAST = CNT_W'(SAMPLE_CYCLES - 1);

  logic [2:0]       state_q;
  logic [2:0]       state_d;
  logic             cnvst_prev_q;
  logic [7:0]       sar_q;
  logic [2:0]       idx_q;
  logic [CNT_W-1:0] smp_cnt_q;
  // Set by the first conversion; until then the negative array stays parked
  // on the bottom reference so the post-reset switch state is fully defined.
  logic             armed_q;

  logic             start_w;
  logic             smp_last_w;
  logic             s_clk_w;
  logic             switch_s_w;
  logic             cmp_clk_w;
  logic             eoc_w;
  logic [8:0]       sca1_top_w;
  logic [8:0]       sca1_btm_w;
  logic [8:0]       sca2_top_w;
  logic [8:0]       sca2_btm_w;

  assign start_w    = bus.cnvst & ~cnvst_prev_q;
  assign smp_last_w = (smp_cnt_q == SMP_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: start edge, sample length, bit index exhaustion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start_w) state_d = ST_SAMPLE;
      ST_SAMPLE:  if (smp_last_w) state_d = ST_BIT_CMP;
      ST_BIT_CMP: state_d = ST_BIT_DEC;
      ST_BIT_DEC: state_d = (idx_q == 3'd0) ? ST_DONE : ST_BIT_CMP;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Datapath: start edge detector, sample counter, successive-approximation register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnvst_prev_q <= 1'b0;
      sar_q        <= 8'h00;
      idx_q        <= 3'd7;
      smp_cnt_q    <= '0;
      armed_q      <= 1'b0;
    end else begin
      cnvst_prev_q <= bus.cnvst;
      case (state_q)
        ST_IDLE: begin
          if (start_w) begin
            sar_q     <= 8'h00;
            idx_q     <= 3'd7;
            smp_cnt_q <= '0;
            armed_q   <= 1'b1;
          end
        end
        ST_SAMPLE: begin
          smp_cnt_q <= smp_cnt_q + CNT_W'(1);
          if (smp_last_w) begin
            sar_q[7] <= 1'b1;
          end
        end
        ST_BIT_DEC: begin
          sar_q[idx_q] <= bus.cmp_out;
          if (idx_q != 3'd0) begin
            sar_q[idx_q - 3'd1] <= 1'b1;
            idx_q               <= idx_q - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode from registered state only; no path from cmp_out or cnvst.
  always_comb begin
    s_clk_w    = (state_q == ST_SAMPLE);
    // Top-plate switch opens one cycle before the bottom plate.
    switch_s_w = (state_q == ST_SAMPLE) && !smp_last_w;
    cmp_clk_w  = (state_q == ST_BIT_CMP);
    eoc_w      = (state_q == ST_DONE);
    // Index 0 is the dummy LSB cap: always on the bottom reference.
    sca1_top_w = {sar_q, 1'b0};
    sca1_btm_w = {~sar_q, 1'b1};
    if (s_clk_w || !armed_q) begin
      sca2_top_w = 9'h000;
      sca2_btm_w = 9'h1FF;
    end else begin
      sca2_top_w = {~sar_q, 1'b0};
      sca2_btm_w = {sar_q, 1'b1};
    end
  end

  assign bus.sar               = sar_q;
  assign bus.eoc               = eoc_w;
  assign bus.cmp_clk           = cmp_clk_w;
  assign bus.s_clk             = s_clk_w;
  assign bus.s_clk_not         = ~s_clk_w;
  assign bus.fine_switch_S     = switch_s_w;
  assign bus.fine_switch_S_not = ~switch_s_w;
  assign bus.fine_sca1_top     = sca1_top_w;
  assign bus.fine_sca1_btm     = sca1_btm_w;
  assign bus.fine_sca2_top     = sca2_top_w;
  assign bus.fine_sca2_btm     = sca2_btm_w;
  assign bus.fine_sca1_top_not = ~sca1_top_w;
  assign bus.fine_sca1_btm_not = ~sca1_btm_w;
  assign bus.fine_sca2_top_not = ~sca2_top_w;
  assign bus.fine_sca2_btm_not = ~sca2_btm_w;

endmodule
`default_nettype wire

// File: tb/tb_sar_adc_logic.sv
`default_nettype none
// ============================================================================
// Module      : tb_sar_adc_logic
// Description : Self-checking bench for sar_adc_logic. A cycle-indexed
//               reference derives every expected output from the start edge,
//               the intended comparator decisions and the cap mapping rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sar_adc_logic;

  localparam int S = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   started = 1'b0;

  always #5 clk = ~clk;

  sar_adc_logic_if bus ();

  sar_adc_logic #(.SAMPLE_CYCLES(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected switch drive follows from the result register and the sampling flag.
  task automatic check_outs(input string ph, input logic [7:0] esar, input logic eeoc,
                            input logic ecmp, input logic es, input logic efs);
    logic [8:0] t1, b1, t2, b2, t1n, b1n, t2n, b2n, ov1, ov2;
    logic       esn, efsn;
    t1 = {esar, 1'b0};
    b1 = {~esar, 1'b1};
    if (es || !started) begin
      t2 = 9'h000;
      b2 = 9'h1FF;
    end else begin
      t2 = {~esar, 1'b0};
      b2 = {esar, 1'b1};
    end
    t1n = ~t1; b1n = ~b1; t2n = ~t2; b2n = ~b2;
    esn = ~es; efsn = ~efs;
    ov1 = bus.fine_sca1_top & bus.fine_sca1_btm;
    ov2 = bus.fine_sca2_top & bus.fine_sca2_btm;
    chk($sformatf("%s.sar", ph),        bus.sar,               esar);
    chk($sformatf("%s.eoc", ph),        bus.eoc,               eeoc);
    chk($sformatf("%s.cmp_clk", ph),    bus.cmp_clk,           ecmp);
    chk($sformatf("%s.s_clk", ph),      bus.s_clk,             es);
    chk($sformatf("%s.switch_S", ph),   bus.fine_switch_S,     efs);
    chk($sformatf("%s.sca1_top", ph),   bus.fine_sca1_top,     t1);
    chk($sformatf("%s.sca1_btm", ph),   bus.fine_sca1_btm,     b1);
    chk($sformatf("%s.sca2_top", ph),   bus.fine_sca2_top,     t2);
    chk($sformatf("%s.sca2_btm", ph),   bus.fine_sca2_btm,     b2);
    chk($sformatf("%s.s_clk_n", ph),    bus.s_clk_not,         esn);
    chk($sformatf("%s.switch_S_n", ph), bus.fine_switch_S_not, efsn);
    chk($sformatf("%s.sca1_top_n", ph), bus.fine_sca1_top_not, t1n);
    chk($sformatf("%s.sca1_btm_n", ph), bus.fine_sca1_btm_not, b1n);
    chk($sformatf("%s.sca2_top_n", ph), bus.fine_sca2_top_not, t2n);
    chk($sformatf("%s.sca2_btm_n", ph), bus.fine_sca2_btm_not, b2n);
    chk($sformatf("%s.overlap1", ph),   ov1,                   9'h000);
    chk($sformatf("%s.overlap2", ph),   ov2,                   9'h000);
  endtask

  // One conversion with decisions d (MSB first). Cycle c counts edges after the
  // start edge E, so eoc is expected in the 20th cycle counting E's cycle as 1.
  // mode 0: 2-cycle cnvst pulse; 1: cnvst held high; 2: extra rising edge
  // during the bit phase; 3: asynchronous reset during the bit-4 compare.
  task automatic run_conv(input string name, input logic [7:0] d, input int mode);
    bus.cnvst = 1'b1;
    for (int c = 0; c <= S + 19; c++) begin
      logic [7:0] esar;
      logic       eeoc, ecmp, es, efs;
      int         j, k, hi;
      tick();
      started = 1'b1;
      esar = d; eeoc = 1'b0; ecmp = 1'b0; es = 1'b0; efs = 1'b0;
      j = c - S;
      k = (j >= 0) ? j / 2 : 0;
      if (c < S) begin
        es   = 1'b1;
        efs  = (c != S - 1);
        esar = 8'h00;
      end else if (c < S + 16) begin
        hi   = (255 << (8 - k)) & 255;
        esar = 8'((int'(d) & hi) | (1 << (7 - k)));
        ecmp = (j % 2 == 0);
      end else if (c == S + 16) begin
        eeoc = 1'b1;
      end
      check_outs($sformatf("%s.c%0d", name, c), esar, eeoc, ecmp, es, efs);

      if (mode == 3 && c == S + 6) begin
        rst_n = 1'b0;
        bus.cnvst = 1'b0;
        started = 1'b0;
        #2;
        check_outs({name, ".async_rst"}, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_outs({name, ".in_rst"}, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        check_outs({name, ".post_rst"}, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        return;
      end

      // Comparator only matters in the decision cycle; elsewhere it is noise.
      if (c >= S && c < S + 16 && (j % 2 == 1))
        bus.cmp_out = d[7 - k];
      else
        bus.cmp_out = 1'($urandom_range(0, 1));

      if (mode != 1 && c == 0) bus.cnvst = 1'b0;
      if (mode == 2 && c == S + 3) bus.cnvst = 1'b1;
      if (mode == 2 && c == S + 7) bus.cnvst = 1'b0;
    end
    bus.cnvst = 1'b0;
    tick();
    check_outs({name, ".idle"}, d, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.cnvst   = 1'b0;
    bus.cmp_out = 1'b0;
    rst_n       = 1'b0;
    started     = 1'b0;

    // Reset held with cnvst toggling: outputs stay at reset values.
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.cnvst = ~bus.cnvst;
      check_outs($sformatf("reset%0d", i), 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    bus.cnvst = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check_outs("idle0", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    run_conv("full", 8'hFF, 0);
    run_conv("zero", 8'h00, 0);
    run_conv("pattern", 8'hA6, 0);
    run_conv("held", 8'($urandom), 1);
    run_conv("second_edge", 8'($urandom), 2);
    run_conv("after_eoc", 8'($urandom), 0);
    run_conv("mid_rst", 8'($urandom), 3);
    run_conv("clean", 8'($urandom), 0);
    for (int i = 0; i < 6; i++) begin
      run_conv($sformatf("rand%0d", i), 8'($urandom), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
